core_icache: RTL

//  Instruction-side responder for the fetch stage: takes the fetch PC and returns the 32-bit instruction.

---
 rtl/core_icache.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/core_icache.sv
// rtl/core_icache.sv - direct-mapped read-only instruction cache with single-line refill
module core_icache #(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] pc,
    output logic [31:0] inst,
    output logic        miss_stall,
    input  logic        invalidate,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(LINES);
    localparam int IDX_LSB = 2 + OFF_W;
    localparam int TAG_LSB = 2 + OFF_W + IDX_W;
    localparam int TAG_W   = 64 - TAG_LSB;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [OFF_W-1:0]   beat_q, beat_d;
    logic               sticky_q, sticky_d;
    logic               mem_req_q, mem_req_d;
    logic [63:0]        mem_addr_q, mem_addr_d;
    logic               data_we;
    logic               tag_we;

    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES][WORDS_PER_LINE];

    // Lookup fields of the current fetch address; pc[1:0] plays no part.
    logic [OFF_W-1:0]   pc_off;
    logic [IDX_W-1:0]   pc_idx;
    logic [TAG_W-1:0]   pc_tag;
    logic               hit;

    assign pc_off = pc[2 +: OFF_W];
    assign pc_idx = pc[IDX_LSB +: IDX_W];
    assign pc_tag = pc[TAG_LSB +: TAG_W];

    // The refill target is the latched line base held on mem_addr.
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;

    assign fill_idx = mem_addr_q[IDX_LSB +: IDX_W];
    assign fill_tag = mem_addr_q[TAG_LSB +: TAG_W];

    // Lookups only succeed in IDLE, so the whole refill reads as a stall.
    assign hit        = (state_q == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign inst       = hit ? data_q[pc_idx][pc_off] : 32'h0;
    assign miss_stall = !hit;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

    // Control state register; reset drops every valid bit and aborts any refill.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            beat_q     <= '0;
            sticky_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            beat_q     <= beat_d;
            sticky_q   <= sticky_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Next-state logic: start a refill on a miss, collect beats, close the line on the last one.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        beat_d     = beat_q;
        sticky_d   = sticky_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        data_we    = 1'b0;
        tag_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (invalidate) begin
                    // The hit result of this cycle stands; only the valid bits go.
                    valid_d = '0;
                end else if (!hit) begin
                    state_d    = REFILL;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {pc[63:IDX_LSB], {IDX_LSB{1'b0}}};
                    beat_d     = '0;
                    sticky_d   = 1'b0;
                end
            end
            REFILL: begin
                if (invalidate) begin
                    // Remember the flush so the line in flight cannot come back valid.
                    valid_d  = '0;
                    sticky_d = 1'b1;
                end
                if (mem_rvalid) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        tag_we    = 1'b1;
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                        beat_d    = '0;
                        if (!(sticky_q || invalidate)) begin
                            valid_d[fill_idx] = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Data and tag storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clock) begin
        if (data_we) begin
            data_q[fill_idx][beat_q] <= mem_rdata;
        end
        if (tag_we) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

endmodule
